// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// neg_if works on a 64-bit container so callers of any width up to 64 can truncate the result.
package div_pkg;

    localparam int MAX_XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // The low bits of a negated zero-extended value are the two's complement at any narrower width
    function automatic logic [MAX_XLEN-1:0] neg_if(input logic [MAX_XLEN-1:0] x, input logic c);
        return c ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB when it does not go negative.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_trial;

    assign w_shifted = {i_rem, i_quo[XLEN-1]};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    assign o_rem = w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/divider.sv
// Iterative radix-2^k restoring integer divider: magnitudes are divided over XLEN/BITS_PER_CYCLE
// cycles, then signs are corrected in a final FIX cycle that also raises the one-cycle done pulse.
module divider
    import div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      sign,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done,
    output logic            busy
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvsr;
    logic             r_qNeg;
    logic             r_rNeg;
    logic             r_divZero;
    logic [XLEN-1:0]  r_quotient;
    logic [XLEN-1:0]  r_remainder;
    logic             r_done;

    logic             w_dvdNeg;
    logic             w_dvsNeg;
    logic [XLEN-1:0]  w_dvdAbs;
    logic [XLEN-1:0]  w_dvsAbs;
    logic [XLEN-1:0]  w_remChain [BITS_PER_CYCLE+1];
    logic [XLEN-1:0]  w_quoChain [BITS_PER_CYCLE+1];

    assign w_dvdNeg = sign[0] & dividend[XLEN-1];
    assign w_dvsNeg = sign[1] & divisor[XLEN-1];
    assign w_dvdAbs = XLEN'(neg_if(MAX_XLEN'(dividend), w_dvdNeg));
    assign w_dvsAbs = XLEN'(neg_if(MAX_XLEN'(divisor), w_dvsNeg));

    assign w_remChain[0] = r_rem;
    assign w_quoChain[0] = r_quo;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .i_rem     (w_remChain[g]),
            .i_quo     (w_quoChain[g]),
            .i_divisor (r_dvsr),
            .o_rem     (w_remChain[g+1]),
            .o_quo     (w_quoChain[g+1])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_qNeg      <= 1'b0;
            r_rNeg      <= 1'b0;
            r_divZero   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem     <= '0;
                        r_quo     <= w_dvdAbs;
                        r_dvsr    <= w_dvsAbs;
                        r_qNeg    <= w_dvdNeg ^ w_dvsNeg;
                        r_rNeg    <= w_dvdNeg;
                        r_divZero <= (divisor == '0);
                        r_count   <= '0;
                        r_state   <= ITER;
                    end
                end
                ITER: begin
                    r_rem   <= w_remChain[BITS_PER_CYCLE];
                    r_quo   <= w_quoChain[BITS_PER_CYCLE];
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(N - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // With a zero divisor every trial succeeds, so rem ends as |dividend| and
                    // re-applying the dividend sign restores the original dividend bits.
                    r_quotient  <= r_divZero ? '1 : XLEN'(neg_if(MAX_XLEN'(r_quo), r_qNeg));
                    r_remainder <= XLEN'(neg_if(MAX_XLEN'(r_rem), r_rNeg));
                    r_done      <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_divider.sv
// Randomized and directed bench for divider, checked against an arithmetic reference model
// that uses 64-bit signed division with truncation toward zero.
module tb_divider;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    divider #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic void refModel(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = s[0] ? longint'($signed(a)) : longint'(a);
        sb = s[1] ? longint'($signed(b)) : longint'(b);
        if (sb == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Called at a negedge; holds start for one cycle and returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        sign     = s;
        dividend = a;
        divisor  = b;
        @(negedge clock);
        start    = 1'b0;
    endtask

    // Waits for done starting from cycle startCyc; returns the cycle number in which done was seen.
    task automatic waitDone(input int startCyc, input bit chkBusy, input string tag, output int lat);
        lat = startCyc;
        while (!done && lat < 60) begin
            if (chkBusy) checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expQ;
        logic [31:0] expR;
        int lat;
        refModel(s, a, b, expQ, expR);
        @(negedge clock);
        applyStimulus(s, a, b);
        waitDone(1, 1'b0, tag, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'd34);
        checkOutput({tag, "_q"}, quotient, expQ);
        checkOutput({tag, "_r"}, remainder, expR);
        @(negedge clock);
        checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int doneCount;
        logic [31:0] expQ;
        logic [31:0] expR;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rs;

        reset    = 1'b1;
        start    = 1'b0;
        sign     = 2'b00;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_q", quotient, 32'd0);
        checkOutput("rst_r", remainder, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Unsigned 100/7 with busy tracked across cycles 1..33
        @(negedge clock);
        applyStimulus(2'b00, 32'd100, 32'd7);
        waitDone(1, 1'b1, "u100_7", lat);
        checkOutput("u100_7_lat", 32'(lat), 32'd34);
        checkOutput("u100_7_busyAtDone", 32'(busy), 32'd0);
        checkOutput("u100_7_q", quotient, 32'd14);
        checkOutput("u100_7_r", remainder, 32'd2);
        @(negedge clock);
        checkOutput("u100_7_donePulse", 32'(done), 32'd0);

        runAndCheck("s_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
        runAndCheck("u_ff_2", 2'b00, 32'hFFFF_FFFF, 32'd2);
        runAndCheck("s_ff_2", 2'b11, 32'hFFFF_FFFF, 32'd2);
        runAndCheck("divzero", 2'b11, 32'h0000_1234, 32'd0);
        runAndCheck("divzeroNeg", 2'b11, 32'h8000_0005, 32'd0);
        runAndCheck("ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        runAndCheck("u_msb_1", 2'b01, 32'h8000_0000, 32'd1);
        runAndCheck("mix_10", 2'b10, 32'd100, 32'hFFFF_FFF9);
        runAndCheck("mix_01", 2'b01, 32'hFFFF_FF9C, 32'd7);

        // start in cycle 10 of a running op is ignored
        @(negedge clock);
        applyStimulus(2'b00, 32'd100, 32'd7);
        repeat (9) @(negedge clock);
        applyStimulus(2'b11, 32'hDEAD_BEEF, 32'd3);
        waitDone(11, 1'b0, "ign", lat);
        checkOutput("ign_lat", 32'(lat), 32'd34);
        checkOutput("ign_q", quotient, 32'd14);
        checkOutput("ign_r", remainder, 32'd2);
        doneCount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("ign_extraDone", 32'(doneCount), 32'd0);

        // start in the done cycle is accepted
        @(negedge clock);
        applyStimulus(2'b00, 32'd1000, 32'd33);
        waitDone(1, 1'b0, "b2bA", lat);
        checkOutput("b2bA_lat", 32'(lat), 32'd34);
        checkOutput("b2bA_q", quotient, 32'd30);
        checkOutput("b2bA_r", remainder, 32'd10);
        applyStimulus(2'b11, 32'hFFFF_FC18, 32'd33);
        waitDone(1, 1'b0, "b2bB", lat);
        checkOutput("b2bB_lat", 32'(lat), 32'd34);
        checkOutput("b2bB_q", quotient, 32'hFFFF_FFE2);
        checkOutput("b2bB_r", remainder, 32'hFFFF_FFF6);

        // Reset in cycle 15 aborts the op
        @(negedge clock);
        applyStimulus(2'b00, 32'd5000, 32'd3);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_q", quotient, 32'd0);
        checkOutput("abort_r", remainder, 32'd0);
        doneCount = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) doneCount++;
        end
        checkOutput("abort_noDone", 32'(doneCount), 32'd0);
        runAndCheck("afterAbort", 2'b00, 32'd5000, 32'd3);

        // Randomized operands, biased toward small, zero and all-ones divisors
        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            refModel(rs, ra, rb, expQ, expR);
            @(negedge clock);
            applyStimulus(rs, ra, rb);
            waitDone(1, 1'b0, "rnd", lat);
            checkOutput("rnd_lat", 32'(lat), 32'd34);
            checkOutput("rnd_q", quotient, expQ);
            checkOutput("rnd_r", remainder, expR);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
